calc_cmd_driver: RTL
====================

# calc_cmd_driver

Command initiator for the synchronous 8-bit accumulator calculator. It queues operation requests from a host, drives the calculator's `entrada`/`codigo` inputs with the correct cycle sequencing, and captures the calculator's `saida` as a result. The result is returned over a valid/ready handshake. It sits between a host (testbench, UART decoder, keypad FSM) and the calculator, and shares `clk`/`rst` with it.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; must also drive the calculator's reset.
- `cmd_valid`  in  1  host presents a command.
- `cmd_ready`  out  1  FIFO not full; a command is accepted on an edge with `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  00 PASS, 01 ADD, 10 SUB, 11 RDACC.
- `cmd_operand`  in  8  operand; ignored for RDACC.
- `res_valid`  out  1  result available; held until accepted.
- `res_ready`  in  1  host accepts the result on an edge with `res_valid && res_ready`.
- `res_data`  out  8  captured calculator output.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `calc_entrada`  out  8  to calculator `entrada`; registered.
- `calc_codigo`  out  3  to calculator `codigo`; registered.
- `calc_saida`  in  8  from calculator `saida`.

## Operation
- Calculator codes driven: 000 show entrada, 001 add, 010 subtract, 011 show accumulator, 111 idle (calculator forces `saida` to 0, accumulator untouched).
- FIFO: `DEPTH` entries of {op[1:0], operand[7:0]}, with wrap-around read/write pointers and a count. `cmd_ready = (count != DEPTH)`.
  - Simultaneous push and pop when full: the push is refused, because `cmd_ready` is already 0.
  - Simultaneous push and pop when empty: not possible, since pop requires count > 0. A command pushed at edge E is first poppable at E+1.
- FSM states: IDLE, ISSUE, READ, CAPTURE, HOLD.
  - IDLE, FIFO non-empty: pop the head.
    - PASS/ADD/SUB: load `calc_codigo` with 000/001/010 and `calc_entrada` with the operand, then go to ISSUE.
    - RDACC: load `calc_codigo` with 011 and `calc_entrada` with 0, then go to READ.
  - IDLE, FIFO empty: stay in IDLE with `calc_codigo` = 111 and `calc_entrada` = 0.
  - ISSUE, ADD/SUB: load 011, go to READ.
  - ISSUE, PASS: load 111, go to CAPTURE.
  - READ: load 111, go to CAPTURE.
  - CAPTURE: `res_data <= calc_saida`, `res_valid <= 1`, go to HOLD.
  - HOLD: wait for `res_ready`.
    - On accept: clear `res_valid` and go to IDLE.
    - `res_data` stays stable while in HOLD.
    - No pop occurs while in HOLD.
- Arithmetic is done in the calculator only; 8-bit wrap-around is passed through unchanged.
- PASS returns the operand and leaves the accumulator unchanged. ADD/SUB return the updated accumulator. RDACC returns the current accumulator.

## Timing
- Reset values:
  - FIFO empty, with pointers and count at 0, so `cmd_ready` = 1.
  - State IDLE.
  - `calc_codigo` = 111, `calc_entrada` = 0.
  - `res_valid` = 0, `res_data` = 0, `busy` = 0.
- Reset mid-operation aborts immediately: all queued commands and any pending result are discarded. The calculator's accumulator is also cleared via the shared reset.
- Latency, counted from the accepting edge E0 with FSM in IDLE and FIFO empty:
  - ADD/SUB: pop at E1, READ at E2, CAPTURE at E3, `res_valid` high after E4.
  - PASS: `res_valid` high after E3.
  - RDACC: `res_valid` high after E3.
- Back-to-back: after the result handshake at edge Eh, the next pop occurs at Eh+1. Minimum ADD/SUB period is 5 cycles.
- `calc_saida` is sampled only in CAPTURE, exactly one cycle after 011 (or 000 for PASS) was presented.
- `busy` is combinational from state and count.

## Test plan
- Reset, then hold `res_ready` = 1 and send ADD 5, then ADD 3 -> results 5 then 8; `res_valid` rises exactly 4 cycles after each command's pop-eligible accept.
- After the above, send SUB 10 -> 254 (8-bit wrap); RDACC -> 254.
- Send PASS 0x5A, then RDACC -> results 0x5A, then the previous accumulator value (unchanged). `calc_codigo` sequence observed: 000, 111, then 011, 111.
- Hold `res_ready` = 0 and push 6 ADD 1 commands back-to-back:
  - 1 enters execution, 4 fill the FIFO, and `cmd_ready` drops so the 6th stalls.
  - `res_data` = 1 is held stable.
  - Release `res_ready` -> results 1, 2, 3, 4, 5, 6 in order.
- Assert `rst` while in READ with 2 commands queued -> next cycle `res_valid` = 0, `cmd_ready` = 1, `busy` = 0, `calc_codigo` = 111. A subsequent RDACC returns 0.
- Toggle `res_ready` randomly -> `res_data` never changes while `res_valid` = 1 && `res_ready` = 0, and no result is lost or duplicated.

Source files
------------

// File: rtl/calc_cmd_driver_if.sv
// Host-side bundle for the calculator command driver:
// command push handshake, result pop handshake and busy flag.
interface calc_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/calc_cmd_driver.sv
// Command initiator for the 8-bit accumulator calculator:
// queues host ops, sequences entrada/codigo, returns saida.
module calc_cmd_driver #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    calc_cmd_driver_if.slave       host,
    output logic [7:0]             calc_entrada,
    output logic [2:0]             calc_codigo,
    input  logic [7:0]             calc_saida
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_RDACC = 2'b11;

    localparam logic [2:0] C_ACC  = 3'b011;
    localparam logic [2:0] C_IDLE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        READ,
        CAPTURE,
        HOLD
    } state_t;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [1:0]    head_op;
    logic [7:0]    head_val;

    state_t     state_q, state_d;
    logic [2:0] cod_q, cod_d;
    logic [7:0] ent_q, ent_d;
    logic [1:0] op_q, op_d;
    logic       rv_q, rv_d;
    logic [7:0] rd_q, rd_d;

    assign host.cmd_ready = (count != FULL);
    assign push           = host.cmd_valid && host.cmd_ready;
    assign head_op        = mem[rptr][9:8];
    assign head_val       = mem[rptr][7:0];

    assign host.res_valid = rv_q;
    assign host.res_data  = rd_q;
    assign host.busy      = (state_q != IDLE) || (count != '0);
    assign calc_codigo    = cod_q;
    assign calc_entrada   = ent_q;

    // FIFO storage; contents need no reset, count guards them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {host.cmd_op, host.cmd_operand};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state and registered calculator/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cod_q   <= C_IDLE;
            ent_q   <= '0;
            op_q    <= OP_PASS;
            rv_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cod_q   <= cod_d;
            ent_q   <= ent_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state: pop, drive the op, read back acc, capture, hold
    always_comb begin
        state_d = state_q;
        cod_d   = cod_q;
        ent_d   = ent_q;
        op_d    = op_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop  = 1'b1;
                    op_d = head_op;
                    if (head_op == OP_RDACC) begin
                        cod_d   = C_ACC;
                        ent_d   = '0;
                        state_d = READ;
                    end else begin
                        cod_d   = {1'b0, head_op};
                        ent_d   = head_val;
                        state_d = ISSUE;
                    end
                end else begin
                    cod_d = C_IDLE;
                    ent_d = '0;
                end
            end
            ISSUE: begin
                if (op_q == OP_PASS) begin
                    cod_d   = C_IDLE;
                    state_d = CAPTURE;
                end else begin
                    cod_d   = C_ACC;
                    state_d = READ;
                end
            end
            READ: begin
                cod_d   = C_IDLE;
                ent_d   = '0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rd_d    = calc_saida;
                rv_d    = 1'b1;
                cod_d   = C_IDLE;
                ent_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (host.res_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
